hangman_main: RTL and testbench

HANGMAN_MAIN -- requirements
Module: hangman_main

---
 rtl/hangman_pkg.sv | 44 ++++
 rtl/hangman_keypad_decoder.sv | 90 +++++++++
 rtl/hangman_main.sv | 202 ++++++++++++++++++++
 tb/tb_hangman_main.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - shared types, ASCII constants and keypad layout for hangman_main
package hangman_pkg;

  typedef enum logic [1:0] {
    HOST_ENTRY = 2'd0,
    PLAY       = 2'd1,
    WIN        = 2'd2,
    LOSE       = 2'd3
  } state_t;

  localparam int WORD_LEN = 5;

  localparam int KEY_SUBMIT = 0;
  localparam int KEY_PZ     = 1;
  localparam int KEY_HO     = 2;
  localparam int KEY_AG     = 3;

  localparam logic [7:0] CH_A          = "A";
  localparam logic [7:0] CH_G          = "G";
  localparam logic [7:0] CH_H          = "H";
  localparam logic [7:0] CH_O          = "O";
  localparam logic [7:0] CH_P          = "P";
  localparam logic [7:0] CH_Z          = "Z";
  localparam logic [7:0] CH_SPACE      = " ";
  localparam logic [7:0] CH_UNDERSCORE = "_";
  localparam logic [7:0] CH_ZERO       = "0";

  localparam logic [39:0] TXT_WORD   = "WORD:";
  localparam logic [55:0] TXT_LETTER = "LETTER:";
  localparam logic [31:0] TXT_SENT   = "SENT";
  localparam logic [39:0] TXT_MISS   = "MISS:";
  localparam logic [55:0] TXT_WIN    = "YOU WIN";
  localparam logic [63:0] TXT_LOSE   = "YOU LOSE";

  // Multi-tap step: advance within the group, or restart at its first letter.
  function automatic logic [7:0] next_tap(input logic valid, input logic [7:0] cur,
                                          input logic [7:0] lo, input logic [7:0] hi);
    if (valid && cur >= lo && cur <= hi) begin
      return (cur == hi) ? lo : cur + 8'd1;
    end
    return lo;
  endfunction

endpackage

// File: rtl/hangman_keypad_decoder.sv
// rtl/hangman_keypad_decoder.sv - keypad synchronizer, debouncer and multi-tap letter entry
module keypad_decoder
  import hangman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic       clear,
  input  logic [3:0] keys,
  output logic       letter_valid,
  output logic [7:0] letter,
  output logic       submit,
  output logic       pz_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    stable;
  logic [3:0]    rise;
  logic [3:0]    key_press;
  logic [CW-1:0] cnt [4];
  logic          cur_valid;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      rise   <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        rise[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          rise[i]   <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Simultaneous edges: keep only the lowest set bit.
  assign key_press = rise & (~rise + 4'd1);
  assign pz_press  = key_press[KEY_PZ];

  // The pending letter stays visible during the submit cycle and is dropped after it.
  assign cur_valid = letter_valid & ~submit;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      letter_valid <= 1'b0;
      letter       <= '0;
      submit       <= 1'b0;
    end else if (clear) begin
      letter_valid <= 1'b0;
      letter       <= '0;
      submit       <= 1'b0;
    end else begin
      submit <= 1'b0;
      if (submit) letter_valid <= 1'b0;
      if (enable) begin
        if (key_press[KEY_SUBMIT]) begin
          submit <= 1'b1;
        end else if (key_press[KEY_PZ]) begin
          letter       <= next_tap(cur_valid, letter, CH_P, CH_Z);
          letter_valid <= 1'b1;
        end else if (key_press[KEY_HO]) begin
          letter       <= next_tap(cur_valid, letter, CH_H, CH_O);
          letter_valid <= 1'b1;
        end else if (key_press[KEY_AG]) begin
          letter       <= next_tap(cur_valid, letter, CH_A, CH_G);
          letter_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hangman_main.sv
// rtl/hangman_main.sv - two-keypad hangman game: word entry, guessing, LCD text and indicators
module hangman_main
  import hangman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_MISSES      = 6
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         role_switch,
  input  logic [3:0]   input_row_host,
  input  logic [3:0]   input_row_player,
  output logic [127:0] host_row1,
  output logic [127:0] host_row2,
  output logic [127:0] play_row1,
  output logic [127:0] play_row2,
  output logic         red,
  output logic         green,
  output logic         blue,
  output logic         error,
  output logic         msg_sent
);

  state_t      state;
  state_t      state_next;
  logic        role_prev;
  logic        clear_keys;
  logic        h_valid, h_submit, h_pz;
  logic [7:0]  h_letter;
  logic        p_valid, p_submit, p_pz;
  logic [7:0]  p_letter;
  logic        sel_valid, sel_submit;
  logic [7:0]  sel_letter;
  logic        letter_ev, commit_ev, restart_ev;
  logic [7:0]  word [WORD_LEN];
  logic [2:0]  len;
  logic [3:0]  misses;
  logic [25:0] guessed;
  logic [4:0]  revealed;
  logic [4:0]  match;
  logic        already, all_revealed, out_of_misses, game_live, word_full;
  logic        error_d, msg_d, red_d, green_d, blue_d;
  logic [7:0]  word_ch [WORD_LEN];
  logic [7:0]  rev_ch [WORD_LEN];
  logic [7:0]  h_ch, p_ch, miss_ch;

  // Pending letters are wiped on a role change and held empty once a game is over.
  assign clear_keys = (role_switch != role_prev) || (state == WIN) || (state == LOSE);

  keypad_decoder #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_host_keys (
    .clk(clk), .nRst(nRst), .enable(~role_switch), .clear(clear_keys),
    .keys(input_row_host), .letter_valid(h_valid), .letter(h_letter),
    .submit(h_submit), .pz_press(h_pz)
  );

  keypad_decoder #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_player_keys (
    .clk(clk), .nRst(nRst), .enable(role_switch), .clear(clear_keys),
    .keys(input_row_player), .letter_valid(p_valid), .letter(p_letter),
    .submit(p_submit), .pz_press(p_pz)
  );

  assign sel_valid     = role_switch ? p_valid  : h_valid;
  assign sel_letter    = role_switch ? p_letter : h_letter;
  assign sel_submit    = role_switch ? p_submit : h_submit;
  assign letter_ev     = sel_submit & sel_valid;
  assign commit_ev     = sel_submit & ~sel_valid;
  assign restart_ev    = h_pz | p_pz;
  assign word_full     = (len == 3'(WORD_LEN));
  assign all_revealed  = &revealed;
  assign out_of_misses = (misses >= 4'(MAX_MISSES));
  assign game_live     = ~all_revealed & ~out_of_misses;

  always_comb begin
    match   = '0;
    already = 1'b0;
    for (int i = 0; i < WORD_LEN; i++) match[i] = (word[i] == sel_letter);
    for (int i = 0; i < 26; i++) begin
      if (guessed[i] && (sel_letter == CH_A + 8'(i))) already = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state    <= HOST_ENTRY;
      red      <= 1'b0;
      green    <= 1'b0;
      blue     <= 1'b0;
      error    <= 1'b0;
      msg_sent <= 1'b0;
    end else begin
      state    <= state_next;
      red      <= red_d;
      green    <= green_d;
      blue     <= blue_d;
      error    <= error_d;
      msg_sent <= msg_d;
    end
  end

  // Win is evaluated before the miss limit.
  always_comb begin
    state_next = state;
    case (state)
      HOST_ENTRY: if (commit_ev && word_full) state_next = PLAY;
      PLAY: begin
        if (all_revealed)       state_next = WIN;
        else if (out_of_misses) state_next = LOSE;
      end
      WIN, LOSE:  if (restart_ev) state_next = HOST_ENTRY;
      default:    state_next = HOST_ENTRY;
    endcase
  end

  always_comb begin
    error_d = 1'b0;
    msg_d   = 1'b0;
    case (state)
      HOST_ENTRY: begin
        if (letter_ev && word_full) error_d = 1'b1;
        if (commit_ev) begin
          if (word_full) msg_d   = 1'b1;
          else           error_d = 1'b1;
        end
      end
      PLAY:    if (game_live && letter_ev && already) error_d = 1'b1;
      default: ;
    endcase
    red_d   = (state_next == LOSE);
    green_d = (state_next == WIN);
    blue_d  = (state_next == PLAY);
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      role_prev <= role_switch;
      len       <= '0;
      misses    <= '0;
      guessed   <= '0;
      revealed  <= '0;
      for (int i = 0; i < WORD_LEN; i++) word[i] <= '0;
    end else begin
      role_prev <= role_switch;
      case (state)
        HOST_ENTRY: begin
          if (letter_ev && !word_full) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (3'(i) == len) word[i] <= sel_letter;
            end
            len <= len + 3'd1;
          end else if (commit_ev && word_full) begin
            misses   <= '0;
            guessed  <= '0;
            revealed <= '0;
          end
        end
        PLAY: begin
          if (game_live && letter_ev && !already) begin
            for (int i = 0; i < 26; i++) begin
              if (sel_letter == CH_A + 8'(i)) guessed[i] <= 1'b1;
            end
            revealed <= revealed | match;
            if (match == '0) misses <= misses + 4'd1;
          end
        end
        default: begin
          if (restart_ev) begin
            len      <= '0;
            misses   <= '0;
            guessed  <= '0;
            revealed <= '0;
            for (int i = 0; i < WORD_LEN; i++) word[i] <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < WORD_LEN; i++) begin
      word_ch[i] = (3'(i) < len) ? word[i] : CH_SPACE;
      rev_ch[i]  = revealed[i] ? word[i] : CH_UNDERSCORE;
    end
    h_ch    = h_valid ? h_letter : CH_SPACE;
    p_ch    = p_valid ? p_letter : CH_SPACE;
    miss_ch = CH_ZERO + {4'd0, misses};
  end

  assign host_row1 = {TXT_WORD, word_ch[0], word_ch[1], word_ch[2], word_ch[3], word_ch[4],
                      {6{CH_SPACE}}};
  assign host_row2 = (state == HOST_ENTRY) ? {TXT_LETTER, h_ch, {8{CH_SPACE}}}
                                           : {TXT_SENT, {12{CH_SPACE}}};
  assign play_row1 = {rev_ch[0], rev_ch[1], rev_ch[2], rev_ch[3], rev_ch[4], {11{CH_SPACE}}};

  always_comb begin
    case (state)
      WIN:     play_row2 = {TXT_WIN, {9{CH_SPACE}}};
      LOSE:    play_row2 = {TXT_LOSE, {8{CH_SPACE}}};
      default: play_row2 = {TXT_MISS, miss_ch, CH_SPACE, p_ch, {8{CH_SPACE}}};
    endcase
  end

endmodule

// File: tb/tb_hangman_main.sv
// tb/tb_hangman_main.sv - randomized self-checking bench for hangman_main against a game model
module tb_hangman_main;

  localparam int D      = 4;
  localparam int MAXM   = 6;
  localparam int SETTLE = D + 10;
  localparam int S_HOST = 0, S_PLAY = 1, S_WIN = 2, S_LOSE = 3;

  logic         tb_clk = 1'b0;
  logic         nRst, role_switch;
  logic [3:0]   input_row_host, input_row_player;
  logic [127:0] host_row1, host_row2, play_row1, play_row2;
  logic         red, green, blue, error, msg_sent;

  always #5 tb_clk = ~tb_clk;

  hangman_main #(.DEBOUNCE_CYCLES(D), .MAX_MISSES(MAXM)) dut (
    .clk(tb_clk), .nRst(nRst), .role_switch(role_switch),
    .input_row_host(input_row_host), .input_row_player(input_row_player),
    .host_row1(host_row1), .host_row2(host_row2), .play_row1(play_row1), .play_row2(play_row2),
    .red(red), .green(green), .blue(blue), .error(error), .msg_sent(msg_sent)
  );

  int n_checks = 0, n_fails = 0;
  int obs_err = 0, obs_msg = 0;
  int exp_err = 0, exp_msg = 0;

  always @(negedge tb_clk) begin
    if (error)    obs_err++;
    if (msg_sent) obs_msg++;
  end

  int         m_state, m_miss, m_role;
  logic [7:0] m_word[$];
  bit         m_guess[26];
  logic [7:0] m_pend[2];
  string      groups[4] = '{"", "PQRSTUVWXYZ", "HIJKLMNO", "ABCDEFG"};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] row(input string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic logic [7:0] pc(input logic [7:0] c);
    return (c == 8'd0) ? 8'h20 : c;
  endfunction

  function automatic void model_reset();
    m_state = S_HOST;
    m_miss  = 0;
    m_word.delete();
    foreach (m_guess[i]) m_guess[i] = 1'b0;
    m_pend[0] = 8'd0;
    m_pend[1] = 8'd0;
  endfunction

  function automatic void model_letter(input logic [7:0] c);
    bit in_word, all_found;
    if (m_state == S_HOST) begin
      if (m_word.size() < 5) m_word.push_back(c);
      else exp_err++;
    end else if (m_state == S_PLAY) begin
      if (m_guess[c - 8'd65]) begin
        exp_err++;
        return;
      end
      m_guess[c - 8'd65] = 1'b1;
      in_word = 0;
      foreach (m_word[i]) if (m_word[i] == c) in_word = 1;
      if (!in_word) m_miss++;
      all_found = 1;
      foreach (m_word[i]) if (!m_guess[m_word[i] - 8'd65]) all_found = 0;
      if (all_found) m_state = S_WIN;
      else if (m_miss >= MAXM) m_state = S_LOSE;
    end
  endfunction

  function automatic void model_tap(input int role, input int b);
    int pos;
    logic [7:0] c;
    if (m_state == S_WIN || m_state == S_LOSE) begin
      if (b == 1) begin
        model_reset();
      end
      return;
    end
    if (role != m_role) return;
    if (b == 0) begin
      c = m_pend[role];
      m_pend[role] = 8'd0;
      if (c != 8'd0) model_letter(c);
      else if (m_state == S_HOST) begin
        if (m_word.size() == 5) begin
          exp_msg++;
          m_state = S_PLAY;
          m_miss  = 0;
          foreach (m_guess[i]) m_guess[i] = 1'b0;
        end else begin
          exp_err++;
        end
      end
      return;
    end
    pos = -1;
    for (int j = 0; j < groups[b].len(); j++) if (groups[b][j] == m_pend[role]) pos = j;
    m_pend[role] = groups[b][(pos + 1) % groups[b].len()];
  endfunction

  task automatic check_all(input string tag);
    string s;
    logic [7:0] c;
    s = "WORD:";
    foreach (m_word[i]) s = $sformatf("%s%c", s, m_word[i]);
    check({tag, "/host_row1"}, host_row1, row(s));
    s = (m_state == S_HOST) ? $sformatf("LETTER:%c", pc(m_pend[0])) : "SENT";
    check({tag, "/host_row2"}, host_row2, row(s));
    s = "";
    for (int i = 0; i < 5; i++) begin
      c = (i < m_word.size() && m_guess[m_word[i] - 8'd65]) ? m_word[i] : 8'h5f;
      s = $sformatf("%s%c", s, c);
    end
    check({tag, "/play_row1"}, play_row1, row(s));
    if (m_state == S_WIN)       s = "YOU WIN";
    else if (m_state == S_LOSE) s = "YOU LOSE";
    else                        s = $sformatf("MISS:%0d %c", m_miss, pc(m_pend[1]));
    check({tag, "/play_row2"}, play_row2, row(s));
    check({tag, "/green"}, 128'(green), 128'(m_state == S_WIN));
    check({tag, "/red"}, 128'(red), 128'(m_state == S_LOSE));
    check({tag, "/blue"}, 128'(blue), 128'(m_state == S_PLAY));
    check({tag, "/error_pulses"}, 128'(obs_err), 128'(exp_err));
    check({tag, "/msg_pulses"}, 128'(obs_msg), 128'(exp_msg));
  endtask

  task automatic tap(input int role, input int b, input int hold);
    @(negedge tb_clk);
    if (role == 0) input_row_host[b] = 1'b1;
    else           input_row_player[b] = 1'b1;
    repeat (hold) @(negedge tb_clk);
    input_row_host   = 4'd0;
    input_row_player = 4'd0;
    repeat (SETTLE) @(negedge tb_clk);
    if (hold >= D) model_tap(role, b);
    check_all($sformatf("tap r%0d b%0d h%0d", role, b, hold));
  endtask

  task automatic type_word(input int role, input string w);
    logic [7:0] c;
    int k, n;
    for (int i = 0; i < w.len(); i++) begin
      c = w[i];
      if (c <= 8'h47)      begin k = 3; n = c - 8'h41 + 1; end
      else if (c <= 8'h4f) begin k = 2; n = c - 8'h48 + 1; end
      else                 begin k = 1; n = c - 8'h50 + 1; end
      for (int j = 0; j < n; j++) tap(role, k, D + 2);
      tap(role, 0, D + 2);
    end
  endtask

  task automatic set_role(input int r);
    @(negedge tb_clk);
    if (r != m_role) begin
      m_pend[0] = 8'd0;
      m_pend[1] = 8'd0;
    end
    role_switch = r[0];
    m_role = r;
    repeat (4) @(negedge tb_clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string w;
    int n;
    nRst = 1'b0;
    role_switch = 1'b0;
    input_row_host = 4'd0;
    input_row_player = 4'd0;
    m_role = 0;
    model_reset();
    repeat (4) @(negedge tb_clk);
    nRst = 1'b1;
    @(negedge tb_clk);
    check_all("reset");
    check("reset/underscores", play_row1, row("_____"));

    tap(0, 3, D - 1);
    tap(0, 3, D);
    set_role(1);
    check_all("role_clear");
    tap(0, 3, D + 2);
    set_role(0);

    type_word(0, "APPLE");
    tap(0, 0, D + 2);
    set_role(1);
    type_word(1, "PHAEL");
    check("apple/win_row", play_row2, row("YOU WIN"));
    tap(0, 1, D + 2);

    set_role(0);
    type_word(0, "CAT");
    tap(0, 0, D + 2);
    type_word(0, "BR");
    type_word(0, "X");
    tap(0, 0, D + 2);
    set_role(1);
    type_word(1, "CC");
    type_word(1, "DFGHIJ");
    check("catbr/red", 128'(red), 128'(1));
    tap(1, 1, D + 2);

    for (int g = 0; g < 4; g++) begin
      set_role(0);
      w = "";
      for (int i = 0; i < 5; i++) w = $sformatf("%s%c", w, 8'h41 + 8'($urandom_range(0, 25)));
      type_word(0, w);
      tap(0, 0, D + 2);
      set_role(1);
      n = 0;
      while (m_state == S_PLAY && n < 30) begin
        if ($urandom_range(0, 1) == 1) type_word(1, $sformatf("%c", w[$urandom_range(0, 4)]));
        else type_word(1, $sformatf("%c", 8'h41 + 8'($urandom_range(0, 25))));
        n++;
      end
      check($sformatf("game%0d/over", g), 128'(green | red), 128'(1));
      tap($urandom_range(0, 1), 1, D + 2);
    end

    set_role(0);
    type_word(0, "HOUSE");
    @(negedge tb_clk);
    input_row_host[0] = 1'b1;
    repeat (D) @(negedge tb_clk);
    nRst = 1'b0;
    repeat (8) @(negedge tb_clk);
    input_row_host = 4'd0;
    nRst = 1'b1;
    model_reset();
    repeat (SETTLE) @(negedge tb_clk);
    check_all("reset_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
